// File: rtl/uart_pkg.sv
// UART receive path shared definitions: FSM state encoding and parity mode codes.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rxState_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser (2 flops, preset high) plus optional 2-of-3 majority voter; UART_RX_MAJORITY_EN enables the voter.
// Latency: rx is the line delayed by 2 cycles; votedBit is combinational on rx and the last two tick samples.
// Backpressure: none, free-running; the voter history shifts on every tick.
module uart_rx_sampler (
  input  logic CLK288MHZ,
  input  logic reset,
  input  logic lineIn,
  input  logic tick,
  output logic rx,
  output logic votedBit
);

  logic syncA;
  logic syncB;

  // Two-stage synchroniser; presets to idle-high so reset never looks like a start edge.
  always_ff @(posedge CLK288MHZ) begin
    if (reset) begin
      syncA <= 1'b1;
      syncB <= 1'b1;
    end else begin
      syncA <= lineIn;
      syncB <= syncA;
    end
  end

  assign rx = syncB;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  // Keep the samples from the two most recent ticks; the live value is the third vote.
  always_ff @(posedge CLK288MHZ) begin
    if (reset) begin
      hist <= 2'b11;
    end else if (tick) begin
      hist <= {hist[0], syncB};
    end
  end

  assign votedBit = (hist[1] & hist[0]) | (hist[1] & syncB) | (hist[0] & syncB);
`else
  logic unusedTick;
  assign unusedTick = tick;
  assign votedBit   = syncB;
`endif

endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver with speculative FIFO write, commit/rollback at stop, false-start and break detection (UART_RX_MAJORITY_EN selects voting).
// Latency: line to rx 2 cycles; every strobe is registered, one cycle after the tick that causes it.
// Backpressure: none; the downstream speculative FIFO must accept one write per frame.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1
) (
  input  logic                 CLK288MHZ,
  input  logic                 reset,
  input  logic                 uart_rxd_out,
  input  logic                 tick,
  output logic                 baudReset,
  output logic [DATA_BITS:0]   dataOut,
  output logic                 writeEn,
  output logic                 commitWrite,
  output logic                 rollbackWrite,
  output logic                 frameErr,
  output logic                 breakDet
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  logic rx;
  logic votedBit;

  uart_rx_sampler sampler (
    .CLK288MHZ (CLK288MHZ),
    .reset     (reset),
    .lineIn    (uart_rxd_out),
    .tick      (tick),
    .rx        (rx),
    .votedBit  (votedBit)
  );

  rxState_t               state, stateNext;
  logic [TW-1:0]          tickCnt, tickCntNext;
  logic [BW-1:0]          bitCnt, bitCntNext;
  logic [DATA_BITS-1:0]   shiftReg, shiftNext;
  logic                   parityAcc, parityAccNext;
  logic [DATA_BITS:0]     dataNext;
  logic                   baudResetNext, writeEnNext, commitNext;
  logic                   rollbackNext, frameErrNext, breakNext;
  logic                   parityErr;
  logic                   tickEn;

  // The tick that lands with baudReset belongs to the old baud phase and is dropped.
  assign tickEn = tick & ~baudReset;

  // State, counters, shift register and every output are registered here.
  always_ff @(posedge CLK288MHZ) begin
    if (reset) begin
      state         <= IDLE;
      tickCnt       <= '0;
      bitCnt        <= '0;
      shiftReg      <= '0;
      parityAcc     <= 1'b0;
      dataOut       <= '0;
      baudReset     <= 1'b0;
      writeEn       <= 1'b0;
      commitWrite   <= 1'b0;
      rollbackWrite <= 1'b0;
      frameErr      <= 1'b0;
      breakDet      <= 1'b0;
    end else begin
      state         <= stateNext;
      tickCnt       <= tickCntNext;
      bitCnt        <= bitCntNext;
      shiftReg      <= shiftNext;
      parityAcc     <= parityAccNext;
      dataOut       <= dataNext;
      baudReset     <= baudResetNext;
      writeEn       <= writeEnNext;
      commitWrite   <= commitNext;
      rollbackWrite <= rollbackNext;
      frameErr      <= frameErrNext;
      breakDet      <= breakNext;
    end
  end

  // Frame sequencing: next state, counter updates and strobe requests.
  always_comb begin
    stateNext     = state;
    tickCntNext   = tickCnt;
    bitCntNext    = bitCnt;
    shiftNext     = shiftReg;
    parityAccNext = parityAcc;
    dataNext      = dataOut;
    baudResetNext = 1'b0;
    writeEnNext   = 1'b0;
    commitNext    = 1'b0;
    rollbackNext  = 1'b0;
    frameErrNext  = 1'b0;
    breakNext     = 1'b0;
    parityErr     = 1'b0;
    case (state)
      IDLE: begin
        if (!rx) begin
          stateNext     = START;
          tickCntNext   = '0;
          baudResetNext = 1'b1;
        end
      end
      START: begin
        if (tickEn) begin
          if (tickCnt == TICK_MID) begin
            tickCntNext = '0;
            if (votedBit) begin
              stateNext = IDLE;
            end else begin
              stateNext     = DATA;
              bitCntNext    = '0;
              parityAccNext = 1'b0;
            end
          end else begin
            tickCntNext = tickCnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (tickEn) begin
          if (tickCnt == TICK_LAST) begin
            tickCntNext   = '0;
            shiftNext     = {votedBit, shiftReg[DATA_BITS-1:1]};
            parityAccNext = parityAcc ^ votedBit;
            if (bitCnt == BIT_LAST) begin
              bitCntNext = '0;
              if (PARITY_MODE == PARITY_NONE) begin
                stateNext   = STOP;
                writeEnNext = 1'b1;
                dataNext    = {1'b0, shiftNext};
              end else begin
                stateNext = PARITY;
              end
            end else begin
              bitCntNext = bitCnt + 1'b1;
            end
          end else begin
            tickCntNext = tickCnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (tickEn) begin
          if (tickCnt == TICK_LAST) begin
            parityErr   = (PARITY_MODE == PARITY_ODD) ? ~(parityAcc ^ votedBit)
                                                      : (parityAcc ^ votedBit);
            tickCntNext = '0;
            bitCntNext  = '0;
            dataNext    = {parityErr, shiftReg};
            writeEnNext = 1'b1;
            stateNext   = STOP;
          end else begin
            tickCntNext = tickCnt + 1'b1;
          end
        end
      end
      STOP: begin
        // bitCnt counts stop bits already seen high, so zero means none were.
        if (tickEn) begin
          if (tickCnt == TICK_LAST) begin
            tickCntNext = '0;
            if (!votedBit) begin
              rollbackNext = 1'b1;
              frameErrNext = 1'b1;
              breakNext    = (shiftReg == '0) && (bitCnt == '0);
              stateNext    = WAIT_HIGH;
            end else if (bitCnt == STOP_LAST) begin
              commitNext = 1'b1;
              stateNext  = IDLE;
            end else begin
              bitCntNext = bitCnt + 1'b1;
            end
          end else begin
            tickCntNext = tickCnt + 1'b1;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame at 8E1, OVERSAMPLE=16, one tick every 4 clocks (64 clocks per bit).
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx_frame;

  logic       CLK288MHZ;
  logic       reset;
  logic       uart_rxd_out;
  logic       tick;
  logic       baudReset;
  logic [8:0] dataOut;
  logic       writeEn;
  logic       commitWrite;
  logic       rollbackWrite;
  logic       frameErr;
  logic       breakDet;

  uart_rx_frame dut (
    .CLK288MHZ     (CLK288MHZ),
    .reset         (reset),
    .uart_rxd_out  (uart_rxd_out),
    .tick          (tick),
    .baudReset     (baudReset),
    .dataOut       (dataOut),
    .writeEn       (writeEn),
    .commitWrite   (commitWrite),
    .rollbackWrite (rollbackWrite),
    .frameErr      (frameErr),
    .breakDet      (breakDet)
  );

  localparam int BIT_CLKS = 64;

  int tests = 0;
  int fails = 0;

  // line model and glitch injector state
  logic lineVal;
  int   glitchTick;
  int   tcnt;
  int   tickNum;
  int   gl;
  logic glitchOn;

  // monitor state
  int         cyc = 0;
  int         nBaud, nWr, nCommit, nRb, nFe, nBrk;
  int         nInv = 0;
  int         wrCyc, cmtCyc;
  logic [8:0] lastData = '0;
  logic       pending = 1'b0;

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       s;
    logic [8:0] expData;
    int         expCommit;
    int         expRb;
    int         expBrk;
  } vec_t;

  vec_t vecs[6];

  initial begin
    CLK288MHZ = 1'b0;
    forever #5 CLK288MHZ = ~CLK288MHZ;
  end

  // Tick generator (realigned by baudReset) and serial line driver with optional 1-tick glitch.
  initial begin
    tick = 1'b0; uart_rxd_out = 1'b1; tcnt = 0; tickNum = 0; gl = -1; glitchOn = 1'b0;
    forever begin
      @(negedge CLK288MHZ);
      if (baudReset === 1'b1) begin
        tcnt = 0; tick = 1'b0; tickNum = 0;
      end else begin
        tcnt = (tcnt == 3) ? 0 : tcnt + 1;
        tick = (tcnt == 3);
        if (tick) tickNum++;
      end
      if (glitchTick > 0 && tick && tickNum == glitchTick - 1) gl = 0;
      else if (gl >= 0) gl++;
      glitchOn = (gl >= 2 && gl <= 5);
      if (gl > 5) gl = -1;
      uart_rxd_out = lineVal & ~glitchOn;
    end
  end

  // Event monitor: counts strobes, captures dataOut at writeEn, tracks protocol invariants.
  always @(posedge CLK288MHZ) begin
    #1;
    cyc++;
    if (reset) begin
      pending  = 1'b0;
      lastData = '0;
    end else begin
      if (baudReset) nBaud++;
      if (!writeEn && dataOut !== lastData) nInv++;
      if (writeEn) begin
        nWr++; wrCyc = cyc; lastData = dataOut;
        if (pending) nInv++;
        pending = 1'b1;
      end
      if (commitWrite) begin
        nCommit++; cmtCyc = cyc;
        if (!pending) nInv++;
        pending = 1'b0;
      end
      if (rollbackWrite) begin
        nRb++;
        if (!pending) nInv++;
        pending = 1'b0;
      end
      if (commitWrite && rollbackWrite) nInv++;
      if (frameErr) begin nFe++; if (!rollbackWrite) nInv++; end
      if (breakDet) begin nBrk++; if (!rollbackWrite) nInv++; end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clearMon();
    nBaud = 0; nWr = 0; nCommit = 0; nRb = 0; nFe = 0; nBrk = 0;
    wrCyc = 0; cmtCyc = 0;
  endtask

  task automatic driveBit(input logic v, input int n);
    lineVal = v;
    repeat (n) @(negedge CLK288MHZ);
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic p, input logic s);
    driveBit(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) driveBit(d[i], BIT_CLKS);
    driveBit(p, BIT_CLKS);
    driveBit(s, BIT_CLKS);
    driveBit(1'b1, 2 * BIT_CLKS);
  endtask

  initial begin
    logic [8:0] expGlitch;
    vecs[0] = '{d: 8'hA5, p: 1'b0, s: 1'b1, expData: 9'h0A5, expCommit: 1, expRb: 0, expBrk: 0};
    vecs[1] = '{d: 8'hA5, p: 1'b1, s: 1'b1, expData: 9'h1A5, expCommit: 1, expRb: 0, expBrk: 0};
    vecs[2] = '{d: 8'h3C, p: 1'b0, s: 1'b0, expData: 9'h03C, expCommit: 0, expRb: 1, expBrk: 0};
    vecs[3] = '{d: 8'h00, p: 1'b0, s: 1'b0, expData: 9'h000, expCommit: 0, expRb: 1, expBrk: 1};
    vecs[4] = '{d: 8'hFF, p: 1'b0, s: 1'b1, expData: 9'h0FF, expCommit: 1, expRb: 0, expBrk: 0};
    vecs[5] = '{d: 8'h01, p: 1'b1, s: 1'b1, expData: 9'h001, expCommit: 1, expRb: 0, expBrk: 0};

    reset = 1'b1; lineVal = 1'b1; glitchTick = 0;
    clearMon();
    repeat (4) @(negedge CLK288MHZ);
    check("reset dataOut", dataOut, 9'h000);
    check("reset strobes", {baudReset, writeEn, commitWrite, rollbackWrite, frameErr, breakDet}, 6'b0);
    reset = 1'b0;
    repeat (8) @(negedge CLK288MHZ);

    // Table of whole frames
    for (int i = 0; i < 6; i++) begin
      clearMon();
      sendFrame(vecs[i].d, vecs[i].p, vecs[i].s);
      check($sformatf("v%0d dataOut", i), lastData, vecs[i].expData);
      check($sformatf("v%0d writeEn", i), nWr, 1);
      check($sformatf("v%0d commit", i), nCommit, vecs[i].expCommit);
      check($sformatf("v%0d rollback", i), nRb, vecs[i].expRb);
      check($sformatf("v%0d frameErr", i), nFe, vecs[i].expRb);
      check($sformatf("v%0d breakDet", i), nBrk, vecs[i].expBrk);
      check($sformatf("v%0d baudReset", i), nBaud, 1);
      if (vecs[i].expCommit == 1)
        check($sformatf("v%0d commit delay", i), cmtCyc - wrCyc, 16 * 4);
    end

    // False start: low for 4 ticks only
    clearMon();
    driveBit(1'b0, 16);
    driveBit(1'b1, 4 * BIT_CLKS);
    check("glitch start baudReset", nBaud, 1);
    check("glitch start writeEn", nWr, 0);
    check("glitch start commit+rollback", nCommit + nRb, 0);

    // Held break for 20 bit times, then a normal frame
    clearMon();
    driveBit(1'b0, 20 * BIT_CLKS);
    check("break baudReset", nBaud, 1);
    check("break writeEn", nWr, 1);
    check("break dataOut", lastData, 9'h000);
    check("break rollback", nRb, 1);
    check("break frameErr", nFe, 1);
    check("break breakDet", nBrk, 1);
    check("break commit", nCommit, 0);
    driveBit(1'b1, 2 * BIT_CLKS);
    clearMon();
    sendFrame(8'h55, 1'b0, 1'b1);
    check("after break dataOut", lastData, 9'h055);
    check("after break commit", nCommit, 1);
    check("after break rollback", nRb, 0);

    // Reset in the middle of data bit 4
    clearMon();
    driveBit(1'b0, BIT_CLKS);
    driveBit(1'b1, BIT_CLKS);
    driveBit(1'b0, 3 * BIT_CLKS);
    driveBit(1'b0, BIT_CLKS / 2);
    reset = 1'b1; lineVal = 1'b1;
    @(negedge CLK288MHZ);
    check("midreset dataOut", dataOut, 9'h000);
    check("midreset strobes", {baudReset, writeEn, commitWrite, rollbackWrite, frameErr, breakDet}, 6'b0);
    @(negedge CLK288MHZ);
    reset = 1'b0;
    driveBit(1'b1, 6 * BIT_CLKS);
    check("midreset no write", nWr + nCommit + nRb, 0);
    clearMon();
    sendFrame(8'h81, 1'b0, 1'b1);
    check("post reset dataOut", lastData, 9'h081);
    check("post reset commit", nCommit, 1);
    check("post reset rollback", nRb, 0);

    // One-tick low glitch exactly at the decision tick of data bit 3
`ifdef UART_RX_MAJORITY_EN
    expGlitch = 9'h0FF;
`else
    expGlitch = 9'h1F7;
`endif
    clearMon();
    glitchTick = 8 + 16 * 4;
    sendFrame(8'hFF, 1'b0, 1'b1);
    glitchTick = 0;
    check("bit glitch dataOut", lastData, expGlitch);
    check("bit glitch commit", nCommit, 1);

    check("protocol invariants", nInv, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
